sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Single-port controller that turns a valid/ready word request bus into
// asynchronous SRAM cycles on one 1M x 32 bank (two 16-bit chips side by side).
// Every SRAM-facing output comes straight from a flop, so the strobes are
// glitch-free. WAIT_CYCLES stretches the read/write strobe for slower parts or
// a faster clock.
//
// Parameters
//   WAIT_CYCLES  extra cycles the strobe stays asserted beyond the first (0..15)
//
// Ports
//   clk_50M      system clock, all state changes on its rising edge
//   reset_n      asynchronous reset, active-low
//   req_valid    request present
//   req_ready    controller idle; a request is taken when valid & ready
//   req_we       1 = write, 0 = read
//   req_addr     byte address; [21:2] is the word address, [1:0] ignored
//   req_be       write byte enables, active-high (ignored on reads)
//   req_wdata    write data
//   rsp_valid    one-cycle pulse: read data valid or write completed
//   rsp_rdata    read data, held until the next read completes
//   ram_data     SRAM data bus, released whenever the controller is not writing
//   ram_addr     SRAM word address
//   ram_be_n     SRAM byte enables, active-low
//   ram_ce_n     SRAM chip enable, active-low
//   ram_oe_n     SRAM output enable, active-low
//   ram_we_n     SRAM write enable, active-low
// -----------------------------------------------------------------------------
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_50M,
  input  logic        reset_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [21:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,

  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,

  inout  wire  [31:0] ram_data,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  // Last value of the wait counter before the strobe ends.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  // Next values for the registered SRAM pins and response outputs.
  logic [19:0] addr_next;
  logic [3:0]  be_n_next;
  logic        ce_n_next;
  logic        oe_n_next;
  logic        we_n_next;
  logic        drive_en;
  logic        drive_en_next;
  logic [31:0] wdata_reg;
  logic [31:0] wdata_next;
  logic        rsp_valid_next;
  logic [31:0] rsp_rdata_next;

  // Byte-offset bits are not part of a word access.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign req_ready = (state == IDLE);

  // The bus is driven only from a register that is set solely in the WR_*
  // states, while ram_oe_n is held high there, so the bus never has two drivers.
  assign ram_data = drive_en ? wdata_reg : 32'hzzzz_zzzz;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    addr_next      = ram_addr;
    be_n_next      = ram_be_n;
    ce_n_next      = ram_ce_n;
    oe_n_next      = ram_oe_n;
    we_n_next      = ram_we_n;
    drive_en_next  = drive_en;
    wdata_next     = wdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;

    unique case (state)
      IDLE: begin
        // req_ready is 1 here, so req_valid alone means accepted.
        if (req_valid) begin
          addr_next = req_addr[21:2];
          ce_n_next = 1'b0;
          if (req_we) begin
            // Address, byte enables and data go out one cycle ahead of the
            // we_n falling edge to give the SRAM its setup time.
            wdata_next    = req_wdata;
            be_n_next     = ~req_be;
            drive_en_next = 1'b1;
            state_next    = WR_SETUP;
          end else begin
            oe_n_next  = 1'b0;
            be_n_next  = 4'h0;
            cnt_next   = 4'd0;
            state_next = RD;
          end
        end
      end

      RD: begin
        if (cnt == WAIT_LAST) begin
          rsp_rdata_next = ram_data;
          rsp_valid_next = 1'b1;
          ce_n_next      = 1'b1;
          oe_n_next      = 1'b1;
          be_n_next      = 4'hF;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      WR_SETUP: begin
        we_n_next  = 1'b0;
        cnt_next   = 4'd0;
        state_next = WR_PULSE;
      end

      WR_PULSE: begin
        if (cnt == WAIT_LAST) begin
          // we_n rises while ce_n, address, be_n and data stay put for one
          // more cycle of hold time.
          we_n_next  = 1'b1;
          state_next = WR_HOLD;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      WR_HOLD: begin
        ce_n_next      = 1'b1;
        be_n_next      = 4'hF;
        drive_en_next  = 1'b0;
        rsp_valid_next = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered SRAM pins, write data and response
  // ---------------------------------------------------------------------------
  // Reset drops any transaction in flight at once: strobes high, bus released
  // and no response is ever produced for it.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= 20'd0;
      ram_be_n  <= 4'hF;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      drive_en  <= 1'b0;
      wdata_reg <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      ram_addr  <= addr_next;
      ram_be_n  <= be_n_next;
      ram_ce_n  <= ce_n_next;
      ram_oe_n  <= oe_n_next;
      ram_we_n  <= we_n_next;
      drive_en  <= drive_en_next;
      wdata_reg <= wdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//
// Three controllers (WAIT_CYCLES = 1, 0, 3), each on its own behavioural
// 32-bit SRAM. The stimulus process pushes the expected response of every
// request into a queue; an independent monitor pops it when rsp_valid fires
// and compares latency, read data, write-strobe length and the address/byte
// enables seen while ce_n is low. It also watches for bus contention and for
// we_n falling while ce_n is high.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  typedef struct {
    int          inst;
    bit          we;
    logic [31:0] rdata;
    int          lat;
    int          we_low;
    logic [3:0]  be_n;
    logic [19:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic model_clr;

  logic [2:0]       req_valid;
  logic [2:0]       req_we;
  logic [2:0][21:0] req_addr;
  logic [2:0][3:0]  req_be;
  logic [2:0][31:0] req_wdata;

  wire  [2:0]       req_ready;
  wire  [2:0]       rsp_valid;
  wire  [2:0][31:0] rsp_rdata;
  wire  [2:0][19:0] ram_addr;
  wire  [2:0][3:0]  ram_be_n;
  wire  [2:0]       ram_ce_n;
  wire  [2:0]       ram_oe_n;
  wire  [2:0]       ram_we_n;
  wire  [2:0]       drive_mon;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   viol     = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs and SRAM models. Unwritten words read as 0xC0DE0000 | word index.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_bank
    localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : 3;

    wire  [31:0] ram_data;
    logic [31:0] mem [64];
    logic [63:0] written;
    logic [5:0]  wa;
    logic [31:0] rd_word;
    logic [31:0] keep;
    logic [31:0] merged;

    sram_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .clk_50M   (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_be    (req_be[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .ram_data  (ram_data),
      .ram_addr  (ram_addr[g]),
      .ram_be_n  (ram_be_n[g]),
      .ram_ce_n  (ram_ce_n[g]),
      .ram_oe_n  (ram_oe_n[g]),
      .ram_we_n  (ram_we_n[g])
    );

    assign drive_mon[g] = u_dut.drive_en;

    assign wa       = ram_addr[g][5:0];
    assign rd_word  = written[wa] ? mem[wa] : (32'hC0DE_0000 | {26'd0, wa});
    assign keep     = {{8{ram_be_n[g][3]}}, {8{ram_be_n[g][2]}},
                       {8{ram_be_n[g][1]}}, {8{ram_be_n[g][0]}}};
    assign merged   = (rd_word & keep) | (ram_data & ~keep);
    assign ram_data = (!ram_ce_n[g] && !ram_oe_n[g]) ? rd_word : 32'hzzzz_zzzz;

    always @(negedge clk) begin
      if (model_clr) begin
        written <= '0;
      end else if (!ram_ce_n[g] && !ram_we_n[g]) begin
        mem[wa]     <= merged;
        written[wa] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string got, input string req);
    n_checks++;
    $display("FAIL %s: got %s, required %s", name, got, req);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard on every rsp_valid
  // ---------------------------------------------------------------------------
  initial begin
    int   acc_cyc [3];
    int   we_cnt [3];
    bit   strobe_bad [3];
    bit   prev_we [3];
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = 0; we_cnt[i] = 0; strobe_bad[i] = 1'b0; prev_we[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            fail_now($sformatf("rsp_unexpected[%0d]", i), "rsp_valid=1", "no response");
          end else begin
            e = exp_q.pop_front();
            check($sformatf("latency[%0d]", i), 64'(cyc - acc_cyc[i]), 64'(e.lat));
            if (e.we) check($sformatf("we_low_cycles[%0d]", i), 64'(we_cnt[i]), 64'(e.we_low));
            else      check($sformatf("rdata[%0d]", i), 64'(rsp_rdata[i]), 64'(e.rdata));
            check($sformatf("addr_be_stable[%0d]", i), 64'(strobe_bad[i]), 64'(0));
          end
        end
        if (!ram_ce_n[i] && exp_q.size() > 0 && exp_q[0].inst == i) begin
          if (ram_addr[i] !== exp_q[0].addr || ram_be_n[i] !== exp_q[0].be_n) strobe_bad[i] = 1'b1;
        end
        if (!ram_we_n[i]) we_cnt[i]++;
        if (drive_mon[i] && !ram_oe_n[i]) viol++;
        if (prev_we[i] && !ram_we_n[i] && ram_ce_n[i]) viol++;
        prev_we[i] = ram_we_n[i];
        if (req_valid[i] && req_ready[i]) begin
          acc_cyc[i]    = cyc + 1;
          we_cnt[i]     = 0;
          strobe_bad[i] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Drives a request and returns just after the accepting edge, req_valid still
  // high. acc is the cycle number of the accepting edge.
  task automatic issue(input int i, input bit we, input logic [21:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input int lat, input int we_low,
                       input bit push, output int acc);
    exp_t e;
    if (push) begin
      e.inst = i; e.we = we; e.rdata = exp_rd; e.lat = lat; e.we_low = we_low;
      e.be_n = we ? ~be : 4'h0;
      e.addr = a[21:2];
      exp_q.push_back(e);
    end
    req_we[i]    = we;
    req_addr[i]  = a;
    req_be[i]    = be;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) fail_now($sformatf("accept_timeout[%0d]", i), "req_ready=0", "req_ready=1");
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("rsp_timeout", $sformatf("%0d pending", exp_q.size()), "0 pending");
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int i, input bit we, input logic [21:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                      input int we_low);
    int acc;
    issue(i, we, a, be, wd, exp_rd, lat, we_low, 1'b1, acc);
    req_valid[i] = 1'b0;
    drain();
  endtask

  initial begin
    int  accs [4];
    bit  seen;
    reset_n   = 1'b0;
    model_clr = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;

    // Reset state of all three controllers.
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_strobes[%0d]", i),
            64'({ram_ce_n[i], ram_oe_n[i], ram_we_n[i], ram_be_n[i]}), 64'h7F);
      check($sformatf("rst_addr[%0d]", i), 64'(ram_addr[i]), 64'h0);
      check($sformatf("rst_rsp[%0d]", i), 64'({rsp_valid[i], rsp_rdata[i]}), 64'h0);
      check($sformatf("rst_bus_released[%0d]", i), 64'(drive_mon[i]), 64'h0);
      check($sformatf("rst_ready[%0d]", i), 64'(req_ready[i]), 64'h1);
    end
    #11;
    reset_n   = 1'b1;
    model_clr = 1'b0;
    @(posedge clk);
    #1;

    // WAIT_CYCLES = 1: write, read back, byte merge, empty byte enables.
    xact(0, 1'b1, 22'h000010, 4'hF,    32'h1234_5678, 32'h0,         4, 2);
    xact(0, 1'b0, 22'h000010, 4'h0,    32'h0,         32'h1234_5678, 2, 0);
    xact(0, 1'b1, 22'h000010, 4'b0010, 32'hAABB_CCDD, 32'h0,         4, 2);
    xact(0, 1'b0, 22'h000010, 4'h0,    32'h0,         32'h1234_CC78, 2, 0);
    xact(0, 1'b1, 22'h000014, 4'h0,    32'hFFFF_FFFF, 32'h0,         4, 2);
    check("rdata_kept_over_write", 64'(rsp_rdata[0]), 64'h1234_CC78);
    xact(0, 1'b0, 22'h000014, 4'h0,    32'h0,         32'hC0DE_0005, 2, 0);

    // Back-to-back reads with req_valid held high.
    for (int k = 0; k < 4; k++)
      issue(0, 1'b0, 22'h000020 + 22'(4 * k), 4'h0, 32'h0,
            32'hC0DE_0008 + 32'(k), 2, 0, 1'b1, accs[k]);
    req_valid[0] = 1'b0;
    drain();
    for (int k = 1; k < 4; k++)
      check($sformatf("b2b_spacing[%0d]", k), 64'(accs[k] - accs[k-1]), 64'd3);

    // WAIT_CYCLES = 0 and 3.
    xact(1, 1'b1, 22'h000010, 4'hF, 32'h1234_5678, 32'h0,         3, 1);
    xact(1, 1'b0, 22'h000010, 4'h0, 32'h0,         32'h1234_5678, 1, 0);
    xact(2, 1'b1, 22'h000010, 4'hF, 32'h1234_5678, 32'h0,         6, 4);
    xact(2, 1'b0, 22'h000010, 4'h0, 32'h0,         32'h1234_5678, 4, 0);

    // Reset in the middle of the write strobe: no response, pins idle at once.
    begin
      int acc;
      issue(0, 1'b1, 22'h000030, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, acc);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ram_we_n[0]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("we_pulse_timeout", "we_n=1", "we_n=0");
    #3;
    reset_n      = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    check("abort_we_ce", 64'({ram_we_n[0], ram_ce_n[0]}), 64'h3);
    check("abort_bus_released", 64'(drive_mon[0]), 64'h0);
    check("abort_rsp", 64'({rsp_valid[0], rsp_rdata[0]}), 64'h0);
    check("abort_addr", 64'(ram_addr[0]), 64'h0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    xact(0, 1'b0, 22'h000010, 4'h0, 32'h0, 32'h1234_CC78, 2, 0);

    repeat (5) @(posedge clk);
    check("no_contention", 64'(viol), 64'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
